// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: loads a kernel and an image from valid/ready streams,
// then walks every window in raster order (one MAC per cycle) and emits acc+bias.
module conv_seq_ctrl #(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K_W    = 2,
    parameter int K_H    = 2,
    parameter int STRIDE = 1,
    parameter int BW     = 7,
    parameter int ACC_W  = 16
) (
    input  logic             clk_en,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BW-1:0]    b0,
    output logic             busy,
    output logic             done,
    input  logic             wgt_valid,
    output logic             wgt_ready,
    input  logic [BW-1:0]    wgt_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [BW-1:0]    pix_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last
);
    localparam int OUT_W = (IMG_W - K_W) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K_H) / STRIDE + 1;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int NTAP  = K_W * K_H;
    localparam int PAW   = $clog2(NPIX);
    localparam int TAW   = $clog2(NTAP);
    localparam int DIM   = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW    = $clog2(DIM) + 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_I, MAC, EMIT, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAW-1:0]   ld_q, ld_d;
    logic [TAW-1:0]   tap_q, tap_d;
    logic [CW-1:0]    kr_q, kr_d, kc_q, kc_d, wr_q, wr_d, wc_q, wc_d;
    logic [ACC_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
    logic [BW-1:0]    bias_q, bias_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             wgt_ready_q, wgt_ready_d, pix_ready_q, pix_ready_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;

    logic             wgt_we, pix_we;
    logic [PAW-1:0]   pix_addr;
    logic [2*BW-1:0]  prod;

    // Buffers hold no reset: every job overwrites them completely.
    logic [BW-1:0] wgt_buf [2**TAW];
    logic [BW-1:0] img_buf [2**PAW];

    always_ff @(posedge clk_en) begin
        if (wgt_we) wgt_buf[ld_q[TAW-1:0]] <= wgt_data;
        if (pix_we) img_buf[ld_q] <= pix_data;
    end

    always_comb begin
        pix_addr = PAW'((int'(wr_q) * STRIDE + int'(kr_q)) * IMG_W
                        + int'(wc_q) * STRIDE + int'(kc_q));
        prod     = (2*BW)'(img_buf[pix_addr]) * (2*BW)'(wgt_buf[tap_q]);
    end

    always_comb begin
        state_d    = state_q;
        ld_d       = ld_q;
        tap_d      = tap_q;
        kr_d       = kr_q;
        kc_d       = kc_q;
        wr_d       = wr_q;
        wc_d       = wc_q;
        acc_d      = acc_q;
        bias_d     = bias_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        wgt_we     = 1'b0;
        pix_we     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                bias_d  = b0;
                ld_d    = '0;
                state_d = LOAD_W;
            end
            LOAD_W: if (wgt_valid) begin
                wgt_we = rst_n;
                if (ld_q == PAW'(NTAP - 1)) begin
                    ld_d    = '0;
                    state_d = LOAD_I;
                end else ld_d = ld_q + PAW'(1);
            end
            LOAD_I: if (pix_valid) begin
                pix_we = rst_n;
                if (ld_q == PAW'(NPIX - 1)) begin
                    ld_d    = '0;
                    tap_d   = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    wr_d    = '0;
                    wc_d    = '0;
                    state_d = MAC;
                end else ld_d = ld_q + PAW'(1);
            end
            MAC: begin
                acc_d = (tap_q == '0) ? ACC_W'(prod) : acc_q + ACC_W'(prod);
                if (tap_q == TAW'(NTAP - 1)) begin
                    tap_d      = '0;
                    kr_d       = '0;
                    kc_d       = '0;
                    out_data_d = acc_d + ACC_W'(bias_q);
                    out_last_d = (wr_q == CW'(OUT_H - 1)) && (wc_q == CW'(OUT_W - 1));
                    state_d    = EMIT;
                end else begin
                    tap_d = tap_q + TAW'(1);
                    if (kc_q == CW'(K_W - 1)) begin
                        kc_d = '0;
                        kr_d = kr_q + CW'(1);
                    end else kc_d = kc_q + CW'(1);
                end
            end
            EMIT: if (out_ready) begin
                if (out_last_q) state_d = DONE;
                else begin
                    state_d = MAC;
                    if (wc_q == CW'(OUT_W - 1)) begin
                        wc_d = '0;
                        wr_d = wr_q + CW'(1);
                    end else wc_d = wc_q + CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Handshake/status outputs are registered copies of the next state.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        wgt_ready_d = (state_d == LOAD_W);
        pix_ready_d = (state_d == LOAD_I);
        out_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ld_q        <= '0;
            tap_q       <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            wr_q        <= '0;
            wc_q        <= '0;
            acc_q       <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wgt_ready_q <= 1'b0;
            pix_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_q        <= ld_d;
            tap_q       <= tap_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            wr_q        <= wr_d;
            wc_q        <= wc_d;
            acc_q       <= acc_d;
            bias_q      <= bias_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wgt_ready_q <= wgt_ready_d;
            pix_ready_q <= pix_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign wgt_ready = wgt_ready_q;
    assign pix_ready = pix_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
